// File: rtl/music_player.sv
// rtl/music_player.sv - note ROM sequencer and square-wave buzzer tone generator
module music_player #(
   parameter int          BEAT_CYCLES = 12_500_000,
   parameter int          GAP_CYCLES  = 500_000,
   parameter int          SONG_LEN    = 176,
   // Nonzero replaces the tone counter wrap point so short beats can show
   // toggling; the registered half_period always keeps the table value.
   parameter logic [19:0] HP_OVERRIDE = 20'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       loop,
   output logic [7:0] rom_addr,
   input  logic [7:0] rom_note,
   output logic       tone,
   output logic [7:0] cur_note,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;
   typedef enum logic [1:0] {ADDR_HOLD, ADDR_ZERO, ADDR_INC} addr_op_t;

   localparam logic [23:0] LAST_BEAT = 24'(BEAT_CYCLES - 3);
   localparam logic [23:0] GAP_START = 24'(BEAT_CYCLES - 2 - GAP_CYCLES);
   localparam logic [8:0]  LAST_ADDR = 9'(SONG_LEN - 1);

   state_t      state, state_next;
   addr_op_t    addr_op;
   logic        done_next;
   logic [23:0] beat_cnt;
   logic [19:0] tone_cnt;
   logic [19:0] half_period;
   logic [19:0] hp_wrap;
   logic        tone_ph;
   logic        last_beat;
   logic        in_gap;
   logic        note_valid;
   logic [6:0]  k;
   logic [2:0]  octave;
   logic [3:0]  semi;
   logic [19:0] hp_base;
   logic [19:0] hp_calc;

   assign busy      = (state != IDLE);
   assign last_beat = (beat_cnt == LAST_BEAT);
   assign in_gap    = (beat_cnt >= GAP_START);
   assign hp_wrap   = (HP_OVERRIDE != 20'd0) ? HP_OVERRIDE : half_period;
   // Tone is only heard in PLAY, outside the articulation gap, and for real notes.
   assign tone      = (state == PLAY) && tone_ph && !in_gap && (cur_note != 8'd0);

   // Note code to half-period: split k = n-1 into octave and semitone, then scale C2..B2.
   always_comb begin
      note_valid = (rom_note != 8'd0) && (rom_note <= 8'd96);
      k          = 7'(rom_note - 8'd1);
      octave     = 3'd0;
      semi       = 4'(k);
      for (int i = 1; i < 8; i++) begin
         if (k >= 7'(12 * i)) begin
            octave = 3'(i);
            semi   = 4'(k - 7'(12 * i));
         end
      end
      case (semi)
         4'd0:    hp_base = 20'd764456;
         4'd1:    hp_base = 20'd721546;
         4'd2:    hp_base = 20'd681050;
         4'd3:    hp_base = 20'd642824;
         4'd4:    hp_base = 20'd606745;
         4'd5:    hp_base = 20'd572691;
         4'd6:    hp_base = 20'd540549;
         4'd7:    hp_base = 20'd510210;
         4'd8:    hp_base = 20'd481574;
         4'd9:    hp_base = 20'd454545;
         4'd10:   hp_base = 20'd429034;
         4'd11:   hp_base = 20'd404954;
         default: hp_base = 20'd0;
      endcase
      hp_calc = hp_base >> octave;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next state and control: stop beats start, start restarts from any state.
   always_comb begin
      state_next = state;
      addr_op    = ADDR_HOLD;
      done_next  = 1'b0;
      if (stop && state != IDLE) begin
         state_next = IDLE;
      end else if (start && !stop) begin
         state_next = FETCH;
         addr_op    = ADDR_ZERO;
      end else begin
         case (state)
            FETCH: state_next = LOAD;
            LOAD:  state_next = PLAY;
            PLAY: begin
               if (last_beat) begin
                  if ({1'b0, rom_addr} < LAST_ADDR) begin
                     state_next = FETCH;
                     addr_op    = ADDR_INC;
                  end else if (loop) begin
                     state_next = FETCH;
                     addr_op    = ADDR_ZERO;
                  end else begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end
               end
            end
            default: state_next = state;
         endcase
      end
   end

   // Datapath: address stepping, note capture at LOAD, beat and tone counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         rom_addr    <= 8'd0;
         cur_note    <= 8'd0;
         half_period <= 20'd1;
         tone_cnt    <= 20'd0;
         tone_ph     <= 1'b0;
         beat_cnt    <= 24'd0;
         done        <= 1'b0;
      end else begin
         done <= done_next;
         case (addr_op)
            ADDR_ZERO: rom_addr <= 8'd0;
            ADDR_INC:  rom_addr <= rom_addr + 8'd1;
            default:   rom_addr <= rom_addr;
         endcase
         if (state == PLAY) begin
            beat_cnt <= beat_cnt + 24'd1;
            if (tone_cnt == hp_wrap - 20'd1) begin
               tone_cnt <= 20'd0;
               tone_ph  <= ~tone_ph;
            end else begin
               tone_cnt <= tone_cnt + 20'd1;
            end
         end
         if (state == LOAD && state_next == PLAY) begin
            cur_note    <= note_valid ? rom_note : 8'd0;
            half_period <= note_valid ? hp_calc : 20'd1;
            tone_cnt    <= 20'd0;
            tone_ph     <= 1'b0;
            beat_cnt    <= 24'd0;
         end
         if (state_next == IDLE) cur_note <= 8'd0;
      end
   end

endmodule

// File: tb/tb_music_player.sv
// tb/tb_music_player.sv - directed self-checking bench for music_player
module tb_music_player;

   logic       clk = 1'b0;
   logic       rst, start, stop, loop;
   logic [7:0] rom_addr, rom_note, cur_note;
   logic       tone, busy, done;
   logic [7:0] rom [0:3];
   logic [7:0] exp_cur [0:3];
   int         tests = 0;
   int         fails = 0;

   music_player #(
      .BEAT_CYCLES(100),
      .GAP_CYCLES (10),
      .SONG_LEN   (4),
      .HP_OVERRIDE(20'd4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .stop    (stop),
      .loop    (loop),
      .rom_addr(rom_addr),
      .rom_note(rom_note),
      .tone    (tone),
      .cur_note(cur_note),
      .busy    (busy),
      .done    (done)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Behavioural note ROM with one clock of read latency.
   always @(posedge clk) rom_note <= rom[rom_addr[1:0]];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Tone with the wrap point forced to 4: toggles every 4 PLAY clocks, silent in gap/rests.
   function automatic logic exp_tone(int pos, logic [7:0] code);
      int b;
      if (pos < 2) return 1'b0;
      b = pos - 2;
      if (b >= 88) return 1'b0;
      if (code == 8'd0 || code > 8'd96) return 1'b0;
      return ((b / 4) % 2) == 1;
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tests++; if (rom_addr !== 8'd0) begin fails++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
      tests++; if (tone !== 1'b0) begin fails++; $display("FAIL reset_tone got %b want 0", tone); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
      tests++; if (cur_note !== 8'd0) begin fails++; $display("FAIL reset_cur_note got %0d want 0", cur_note); end
   endtask

   task automatic test_start_latency();
      pulse_start();
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL start_busy got %b want 1", busy); end
      tests++; if (rom_addr !== 8'd0) begin fails++; $display("FAIL start_rom_addr got %0d want 0", rom_addr); end
      tick(); tick();
      tests++; if (cur_note !== 8'd46) begin fails++; $display("FAIL start_cur_note got %0d want 46", cur_note); end
      tests++; if (dut.half_period !== 20'd56818) begin fails++; $display("FAIL hp_code46 got %0d want 56818", dut.half_period); end
      pulse_stop();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_stop_idle got %b want 0", busy); end
   endtask

   task automatic test_full_song();
      int cyc, entry, pos;
      loop = 1'b0;
      pulse_start();
      for (cyc = 1; cyc <= 400; cyc++) begin
         entry = (cyc - 1) / 100;
         pos   = (cyc - 1) % 100;
         tests++; if (rom_addr !== 8'(entry)) begin fails++; $display("FAIL song_rom_addr cyc %0d got %0d want %0d", cyc, rom_addr, entry); end
         tests++; if (busy !== 1'b1) begin fails++; $display("FAIL song_busy cyc %0d got %b want 1", cyc, busy); end
         tests++; if (done !== 1'b0) begin fails++; $display("FAIL song_done_early cyc %0d got %b want 0", cyc, done); end
         tests++; if (tone !== exp_tone(pos, rom[entry])) begin fails++; $display("FAIL song_tone cyc %0d got %b want %b", cyc, tone, exp_tone(pos, rom[entry])); end
         if (pos >= 2) begin
            tests++; if (cur_note !== exp_cur[entry]) begin fails++; $display("FAIL song_cur_note cyc %0d got %0d want %0d", cyc, cur_note, exp_cur[entry]); end
         end
         if (entry == 2 && pos == 2) begin
            tests++; if (dut.half_period !== 20'd764456) begin fails++; $display("FAIL hp_code1 got %0d want 764456", dut.half_period); end
         end
         tick();
      end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL song_done got %b want 1", done); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL song_end_busy got %b want 0", busy); end
      tests++; if (cur_note !== 8'd0) begin fails++; $display("FAIL song_end_cur_note got %0d want 0", cur_note); end
      tick();
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL song_done_width got %b want 0", done); end
   endtask

   task automatic test_loop();
      int cyc, entry, pos;
      loop = 1'b1;
      pulse_start();
      for (cyc = 1; cyc <= 550; cyc++) begin
         entry = ((cyc - 1) / 100) % 4;
         pos   = (cyc - 1) % 100;
         tests++; if (rom_addr !== 8'(entry)) begin fails++; $display("FAIL loop_rom_addr cyc %0d got %0d want %0d", cyc, rom_addr, entry); end
         tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL loop_busy_done cyc %0d got %b%b want 10", cyc, busy, done); end
         tests++; if (tone !== exp_tone(pos, rom[entry])) begin fails++; $display("FAIL loop_tone cyc %0d got %b want %b", cyc, tone, exp_tone(pos, rom[entry])); end
         tick();
      end
      loop = 1'b0;
      pulse_stop();
   endtask

   task automatic test_stop();
      pulse_start();
      repeat (249) tick();
      tests++; if (rom_addr !== 8'd2) begin fails++; $display("FAIL stop_pre_addr got %0d want 2", rom_addr); end
      pulse_stop();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stop_busy got %b want 0", busy); end
      tests++; if (tone !== 1'b0) begin fails++; $display("FAIL stop_tone got %b want 0", tone); end
      tests++; if (cur_note !== 8'd0) begin fails++; $display("FAIL stop_cur_note got %0d want 0", cur_note); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL stop_done got %b want 0", done); end
      repeat (5) tick();
      tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL stop_idle got %b%b want 00", busy, done); end
      pulse_start();
      tests++; if (rom_addr !== 8'd0 || busy !== 1'b1) begin fails++; $display("FAIL stop_restart got addr %0d busy %b want 0 1", rom_addr, busy); end
      tick(); tick();
      tests++; if (cur_note !== 8'd46) begin fails++; $display("FAIL stop_restart_note got %0d want 46", cur_note); end
      pulse_stop();
   endtask

   task automatic test_start_stop_same();
      pulse_start();
      repeat (49) tick();
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      tests++; if (busy !== 1'b0 || cur_note !== 8'd0 || tone !== 1'b0) begin fails++; $display("FAIL both_busy got busy %b note %0d tone %b want 0 0 0", busy, cur_note, tone); end
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL both_idle got %b want 0", busy); end
   endtask

   task automatic test_rst_mid();
      pulse_start();
      repeat (6) tick();
      tests++; if (tone !== 1'b1) begin fails++; $display("FAIL rst_pre_tone got %b want 1", tone); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++; if (tone !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rst_mid got tone %b busy %b done %b want 0 0 0", tone, busy, done); end
      tests++; if (rom_addr !== 8'd0 || cur_note !== 8'd0) begin fails++; $display("FAIL rst_mid_regs got addr %0d note %0d want 0 0", rom_addr, cur_note); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      pulse_start();
      repeat (149) tick();
      tests++; if (rom_addr !== 8'd1) begin fails++; $display("FAIL b2b_pre_addr got %0d want 1", rom_addr); end
      pulse_start();
      tests++; if (rom_addr !== 8'd0 || tone !== 1'b0) begin fails++; $display("FAIL b2b_restart got addr %0d tone %b want 0 0", rom_addr, tone); end
      for (cyc = 1; cyc <= 100; cyc++) begin
         tests++; if (rom_addr !== 8'd0) begin fails++; $display("FAIL b2b_hold cyc %0d got %0d want 0", cyc, rom_addr); end
         if (cyc == 3) begin
            tests++; if (cur_note !== 8'd46) begin fails++; $display("FAIL b2b_note got %0d want 46", cur_note); end
         end
         tick();
      end
      tests++; if (rom_addr !== 8'd1) begin fails++; $display("FAIL b2b_next got %0d want 1", rom_addr); end
      pulse_stop();
   endtask

   initial begin
      rom[0] = 8'd46; rom[1] = 8'd0; rom[2] = 8'd1; rom[3] = 8'd97;
      exp_cur[0] = 8'd46; exp_cur[1] = 8'd0; exp_cur[2] = 8'd1; exp_cur[3] = 8'd0;
      test_reset();
      test_start_latency();
      test_full_song();
      test_loop();
      test_stop();
      test_start_stop_same();
      test_rst_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
